ir_nec_rx: RTL
==============

# ir_nec_rx

Parametrised NEC infrared frame receiver, the successor to the fixed-timing 32-bit IR decoder. It measures falling-edge-to-falling-edge intervals on the demodulated IR receiver output. From these it decodes leader, data and repeat codes, validates the address and command complement bytes, and presents the decoded address and command to the host through a valid/ack handshake. It sits between the IR receiver pin and the command-dispatch logic.

## Interface
- `CLK_HZ`, 25000000: clk frequency in Hz.
- `TICK_US`, 10: interval measurement resolution in µs.
- `TOL_PCT`, 10: symmetric acceptance window on every nominal interval, in percent.
- `TIMEOUT_US`, 15000: edge silence in µs that aborts a reception.
- `EXT_ADDR`, 0: selects the address format.
  - 0: byte1 must equal ~byte0; `addr` = {8'h00, byte0}.
  - 1: 16-bit address {byte1, byte0}, no address check.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: receiver enable.
- `ir_n` in 1: demodulated IR input, active-low (burst = 0), asynchronous.
- `ack` in 1: host acknowledge of `valid`.
- `valid` out 1: a decoded frame is held on `addr`/`cmd`.
- `addr` out 16: decoded address.
- `cmd` out 8: decoded command.
- `overrun` out 1: a good frame was dropped while `valid` was high (sticky).
- `rpt_stb` out 1: one-clk pulse per accepted repeat code.
- `err_stb` out 1: one-clk pulse per malformed or failed frame.

## Operation
- `ir_n` passes through a 2-flop synchroniser. A falling edge is detected on the registered synchronised value.
- The tick prescaler emits a one-clk pulse every CLK_HZ/1e6*TICK_US clocks.
- The 16-bit interval counter counts ticks and saturates at 0xFFFF. It clears on every falling edge.
- Nominal intervals, converted to ticks as localparams, each accepted within ±TOL_PCT (integer math, window bounds inclusive):
  - LEAD: 13500 µs.
  - RPT: 11250 µs.
  - ONE: 2250 µs.
  - ZERO: 1125 µs.
- FSM states: IDLE, SYNC, DATA.
  - IDLE: on a falling edge, clear the counter and go to SYNC.
  - SYNC, on a falling edge:
    - LEAD: clear the shift register and bit count, go to DATA.
    - RPT: pulse `rpt_stb` if a good frame has been decoded since reset/enable, otherwise ignore; stay in SYNC.
    - Any other interval: stay in SYNC.
  - DATA, on a falling edge:
    - ZERO or ONE: shift the bit into shift[31], with the existing contents moving right (LSB-first), and increment the bit count.
    - Any other interval: pulse `err_stb` and go to SYNC.
    - On the 32nd bit (the edge of the stop burst): run the checks and go to SYNC.
- Checks on the 32-bit word:
  - byte3 must equal ~byte2.
  - The address check applies per EXT_ADDR.
  - Pass: load `addr`/`cmd` and set `valid`. If `valid` is already high and `ack` is low, do not load and set `overrun` instead.
  - Fail: pulse `err_stb`.
- Timeout: the counter reaching TIMEOUT_US in SYNC or DATA returns the FSM to IDLE. A timeout in DATA also pulses `err_stb`.
- `enable` low: the FSM is forced to IDLE, the counter and bit count are cleared, and the repeat-eligibility flag is cleared. The held `valid`/`addr`/`cmd`/`overrun` are retained, and `ack` still works.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 1.
- `valid`, `rpt_stb` and `err_stb` assert exactly 4 clk after the falling edge at the `ir_n` pin. The breakdown is 2 sync + 1 edge register + 1 output register.
- `valid` stays high until `ack` is sampled high. `valid` clears on the next clk.
- Same-cycle events:
  - `ack` and a good-frame load in the same cycle: the new data loads, `valid` stays 1, and `overrun` is not set.
  - `ack` while `valid` is low: ignored.
- `overrun` clears on `ack`.
- Reset mid-frame: everything returns to its reset values asynchronously. The first frame after reset needs a full leader.

## Structure
- Package `ir_pkg` holds:
  - the FSM state enum;
  - the NEC nominal µs constants;
  - a function converting µs and tolerance to min/max tick bounds.
- Sub-module `ir_tick_gen`: the prescaler, with parameters CLK_HZ and TICK_US and output `tick`.

## Test plan
All scenarios use default parameters at 25 MHz.
- Frame bytes 04 FB 08 F7 -> `valid`=1, `addr`=0x0004, `cmd`=0x08 at 4 clk after the stop-burst edge. `ack` -> `valid`=0 on the next clk.
- Repeat code after that frame -> one `rpt_stb` pulse. Repeat code after reset with no prior frame -> no pulse.
- Bit-1 interval of 2470 µs -> accepted. Bit-1 interval of 2500 µs -> `err_stb`, FSM in SYNC, `valid` stays 0.
- Frame bytes 04 FB 08 F6 -> `err_stb`, no `valid`. With EXT_ADDR=1, bytes 34 12 08 F7 -> `addr`=0x1234.
- Second good frame without `ack` -> `overrun`=1 and the first frame's data retained. Second good frame with `ack` in the load cycle -> new data, `overrun`=0.
- Input stops after 10 data bits -> `err_stb` after 15 ms, FSM in IDLE. Reset asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ir_nec_rx_pkg.sv
// Shared types and NEC timing constants for the IR receiver.
// us_to_ticks turns a nominal microsecond interval into inclusive tick bounds.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int LEAD_US = 13500;
  localparam int RPT_US  = 11250;
  localparam int ONE_US  = 2250;
  localparam int ZERO_US = 1125;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
  } tick_bounds_t;

  function automatic tick_bounds_t us_to_ticks(input int us, input int tol_pct,
                                               input int tick_us);
    tick_bounds_t b;
    b.lo = 16'((us * (100 - tol_pct)) / (100 * tick_us));
    b.hi = 16'((us * (100 + tol_pct)) / (100 * tick_us));
    return b;
  endfunction

endpackage

// File: rtl/ir_nec_rx_tick_gen.sv
// Free-running prescaler: one-clk tick every CLK_HZ*TICK_US/1e6 clocks.
module ir_tick_gen #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_US = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam longint DIV_RAW = (longint'(CLK_HZ) * longint'(TICK_US)) / 1000000;
  localparam int DIV = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: measures falling-edge intervals, decodes leader/data/repeat,
// validates complement bytes and hands address/command to the host via valid/ack.
module ir_nec_rx
  import ir_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int TICK_US    = 10,
  parameter int TOL_PCT    = 10,
  parameter int TIMEOUT_US = 15000,
  parameter int EXT_ADDR   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ir_n,
  input  logic        ack,
  output logic        valid,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        overrun,
  output logic        rpt_stb,
  output logic        err_stb
);

  localparam tick_bounds_t LEAD_B = us_to_ticks(LEAD_US, TOL_PCT, TICK_US);
  localparam tick_bounds_t RPT_B  = us_to_ticks(RPT_US, TOL_PCT, TICK_US);
  localparam tick_bounds_t ONE_B  = us_to_ticks(ONE_US, TOL_PCT, TICK_US);
  localparam tick_bounds_t ZERO_B = us_to_ticks(ZERO_US, TOL_PCT, TICK_US);
  localparam logic [15:0] TIMEOUT_TICKS = 16'(TIMEOUT_US / TICK_US);

  function automatic logic in_win(input logic [15:0] v, input tick_bounds_t b);
    return (v >= b.lo) && (v <= b.hi);
  endfunction

  logic        tick;
  logic        ir_s1, ir_s2, ir_d, fall;
  logic [15:0] cnt;
  state_t      state;
  logic [30:0] shift;
  logic [4:0]  bit_cnt;
  logic        good_seen;

  logic        is_lead, is_rpt, is_one, is_zero, timed_out, word_ok;
  logic [31:0] word;
  logic [15:0] addr_next;

  ir_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_US(TICK_US)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchroniser, then a registered falling-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
      ir_d  <= 1'b1;
      fall  <= 1'b0;
    end else begin
      ir_s1 <= ir_n;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
      fall  <= ir_d & ~ir_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || fall) begin
      cnt <= '0;
    end else if (tick && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  // LEAD and RPT windows overlap at default tolerance; LEAD wins in SYNC.
  assign is_lead   = in_win(cnt, LEAD_B);
  assign is_rpt    = in_win(cnt, RPT_B);
  assign is_one    = in_win(cnt, ONE_B);
  assign is_zero   = in_win(cnt, ZERO_B);
  assign timed_out = (cnt >= TIMEOUT_TICKS);

  assign word      = {is_one, shift};
  assign word_ok   = (word[31:24] == ~word[23:16]) &&
                     ((EXT_ADDR != 0) || (word[15:8] == ~word[7:0]));
  assign addr_next = (EXT_ADDR != 0) ? word[15:0] : {8'h00, word[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      good_seen <= 1'b0;
      valid     <= 1'b0;
      addr      <= '0;
      cmd       <= '0;
      overrun   <= 1'b0;
      rpt_stb   <= 1'b0;
      err_stb   <= 1'b0;
    end else begin
      rpt_stb <= 1'b0;
      err_stb <= 1'b0;
      if (ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (!enable) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        good_seen <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fall) state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (fall) begin
              if (is_lead) begin
                shift   <= '0;
                bit_cnt <= '0;
                state   <= ST_DATA;
              end else if (is_rpt && good_seen) begin
                rpt_stb <= 1'b1;
              end
            end else if (timed_out) begin
              state <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (fall) begin
              if (is_one || is_zero) begin
                shift   <= word[31:1];
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                  state <= ST_SYNC;
                  if (word_ok) begin
                    good_seen <= 1'b1;
                    // A held frame not being acknowledged this cycle is kept.
                    if (valid && !ack) begin
                      overrun <= 1'b1;
                    end else begin
                      addr  <= addr_next;
                      cmd   <= word[23:16];
                      valid <= 1'b1;
                    end
                  end else begin
                    err_stb <= 1'b1;
                  end
                end
              end else begin
                err_stb <= 1'b1;
                state   <= ST_SYNC;
              end
            end else if (timed_out) begin
              err_stb <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
